operand_latch_bank: RTL and testbench

Parametrised successor to the two-operand button latch. It captures switch data into CHANNELS registers of WIDTH bits each. Save buttons are synchronised and debounced on-chip, and each button press produces exactly one load. Two load modes exist: direct, with one button per channel, and sequential, with one button and an auto-advancing pointer. Per-channel valid flags and a load strobe tell the downstream adder/UART formatter when a complete operand set is ready.

---
 rtl/operand_latch_bank.sv | 134 +++++++++++++
 tb/tb_operand_latch_bank.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/operand_latch_bank.sv
// operand_latch_bank: captures switch data into CHANNELS operand registers.
// Every save button is synchronised and debounced on-chip; a debounced press
// produces exactly one load. Direct mode uses one button per channel,
// sequential mode uses a single button and an auto-advancing pointer.
// Per-channel valid flags and a registered load strobe tell downstream logic
// when a complete operand set is ready.
module operand_latch_bank #(
    parameter int WIDTH     = 4,
    parameter int CHANNELS  = 2,
    parameter int DB_CYCLES = 4,
    localparam int PTR_W    = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic [WIDTH-1:0]          data_input,
    input  logic [CHANNELS-1:0]       save_n,
    input  logic                      seq_save_n,
    input  logic                      seq_mode,
    input  logic                      clear,
    output logic [CHANNELS*WIDTH-1:0] q,
    output logic [CHANNELS-1:0]       valid,
    output logic                      all_valid,
    output logic                      load_strobe,
    output logic [PTR_W-1:0]          seq_ptr
);

    // Buttons 0..CHANNELS-1 are the direct-mode saves, button CHANNELS is the
    // sequential-mode save.
    localparam int NBTN  = CHANNELS + 1;
    localparam int CNT_W = $clog2(DB_CYCLES + 1);

    logic [NBTN-1:0]     raw_n;
    logic [NBTN-1:0]     sync_p0;
    logic [NBTN-1:0]     sync_p1;
    logic [NBTN-1:0]     db_lvl;
    logic [NBTN-1:0]     db_lvl_d;
    logic [CNT_W-1:0]    db_cnt [NBTN];
    logic [NBTN-1:0]     press_ev;
    logic [CHANNELS-1:0] load_mask;
    logic                ld_p1;
    logic                ptr_wrap;

    assign raw_n = {seq_save_n, save_n};

    // Press event: debounced level just fell from released (1) to pressed (0).
    assign press_ev = db_lvl_d & ~db_lvl;

    // Synchronise each button and accept a level change only after it has
    // been seen DB_CYCLES consecutive cycles; any match restarts the count.
    always_ff @(posedge clk) begin
        if (reset_n) begin
            sync_p0  <= '1;
            sync_p1  <= '1;
            db_lvl   <= '1;
            db_lvl_d <= '1;
            for (int b = 0; b < NBTN; b++) begin
                db_cnt[b] <= '0;
            end
        end else begin
            // Synchroniser stage boundary
            sync_p0  <= raw_n;
            sync_p1  <= sync_p0;
            db_lvl_d <= db_lvl;
            for (int b = 0; b < NBTN; b++) begin
                if (sync_p1[b] != db_lvl[b]) begin
                    if (db_cnt[b] == CNT_W'(DB_CYCLES - 1)) begin
                        db_lvl[b] <= sync_p1[b];
                        db_cnt[b] <= '0;
                    end else begin
                        db_cnt[b] <= db_cnt[b] + 1'b1;
                    end
                end else begin
                    db_cnt[b] <= '0;
                end
            end
        end
    end

    assign ptr_wrap = (seq_ptr == PTR_W'(CHANNELS - 1));

    // Decide which channels load this cycle; clear discards any press event.
    always_comb begin
        load_mask = '0;
        if (seq_mode) begin
            if (press_ev[CHANNELS]) begin
                for (int i = 0; i < CHANNELS; i++) begin
                    if (seq_ptr == PTR_W'(i)) begin
                        load_mask[i] = 1'b1;
                    end
                end
            end
        end else begin
            load_mask = press_ev[CHANNELS-1:0];
        end
        if (clear) begin
            load_mask = '0;
        end
    end

    // Operand registers, valid flags, sequential pointer and load strobe.
    always_ff @(posedge clk) begin
        if (reset_n) begin
            q           <= '0;
            valid       <= '0;
            seq_ptr     <= '0;
            ld_p1       <= 1'b0;
            load_strobe <= 1'b0;
        end else begin
            // Load stage boundary: the strobe follows one edge after the load,
            // judged against the valid flags that load produced.
            ld_p1       <= |load_mask;
            load_strobe <= ld_p1 & (&valid);
            for (int i = 0; i < CHANNELS; i++) begin
                if (load_mask[i]) begin
                    q[i*WIDTH +: WIDTH] <= data_input;
                end
            end
            if (clear) begin
                valid   <= '0;
                seq_ptr <= '0;
            end else begin
                valid <= valid | load_mask;
                if (!seq_mode) begin
                    seq_ptr <= '0;
                end else if (press_ev[CHANNELS]) begin
                    seq_ptr <= ptr_wrap ? '0 : seq_ptr + 1'b1;
                end
            end
        end
    end

    assign all_valid = &valid;

endmodule

// File: tb/tb_operand_latch_bank.sv
// Directed bench for operand_latch_bank with WIDTH=4, CHANNELS=2, DB_CYCLES=4.
module tb_operand_latch_bank;

    localparam int WIDTH     = 4;
    localparam int CHANNELS  = 2;
    localparam int DB_CYCLES = 4;
    localparam int PTR_W     = 1;

    logic                      clk = 1'b0;
    logic                      reset_n;
    logic [WIDTH-1:0]          data_input;
    logic [CHANNELS-1:0]       save_n;
    logic                      seq_save_n;
    logic                      seq_mode;
    logic                      clear;
    logic [CHANNELS*WIDTH-1:0] q;
    logic [CHANNELS-1:0]       valid;
    logic                      all_valid;
    logic                      load_strobe;
    logic [PTR_W-1:0]          seq_ptr;

    int n_vec = 0;
    int n_err = 0;
    int strb;

    operand_latch_bank #(
        .WIDTH(WIDTH),
        .CHANNELS(CHANNELS),
        .DB_CYCLES(DB_CYCLES)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .data_input(data_input),
        .save_n(save_n),
        .seq_save_n(seq_save_n),
        .seq_mode(seq_mode),
        .clear(clear),
        .q(q),
        .valid(valid),
        .all_valid(all_valid),
        .load_strobe(load_strobe),
        .seq_ptr(seq_ptr)
    );

    always #5 clk = ~clk;

    task automatic chk_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One active edge, then settle before driving or sampling.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run(input int n, inout int s);
        for (int i = 0; i < n; i++) begin
            tick();
            if (load_strobe) s++;
        end
    endtask

    // Hold a button low for `hold` edges, release it, let it settle; count strobes.
    task automatic press(input int btn, input int hold, output int s);
        s = 0;
        if (btn < CHANNELS) save_n[btn] = 1'b0;
        else seq_save_n = 1'b0;
        run(hold, s);
        save_n     = '1;
        seq_save_n = 1'b1;
        run(10, s);
    endtask

    initial begin
        reset_n    = 1'b1;
        data_input = '0;
        save_n     = '1;
        seq_save_n = 1'b1;
        seq_mode   = 1'b0;
        clear      = 1'b0;

        // Reset with buttons released
        for (int i = 0; i < 3; i++) tick();
        chk_val("rst_q", q, 8'h00);
        chk_val("rst_valid", valid, 2'b00);
        chk_val("rst_all_valid", all_valid, 1'b0);
        chk_val("rst_strobe", load_strobe, 1'b0);
        chk_val("rst_ptr", seq_ptr, 1'b0);
        reset_n = 1'b0;
        tick();

        // Direct load of channel 0: lands on edge 6 after the first low sample
        data_input = 4'h5;
        save_n[0]  = 1'b0;
        for (int i = 0; i < 6; i++) tick();
        chk_val("d0_before_edge6", q, 8'h00);
        tick();
        chk_val("d0_q", q, 8'h05);
        chk_val("d0_valid", valid, 2'b01);
        chk_val("d0_all_valid", all_valid, 1'b0);
        strb = 0;
        run(13, strb);
        save_n = '1;
        run(10, strb);
        chk_val("d0_no_strobe", strb, 0);
        chk_val("d0_hold_q", q, 8'h05);

        // Direct load of channel 1 completes the set; strobe one edge after load
        data_input = 4'hA;
        save_n[1]  = 1'b0;
        for (int i = 0; i < 7; i++) tick();
        chk_val("d1_q", q, 8'hA5);
        chk_val("d1_valid", valid, 2'b11);
        chk_val("d1_all_valid", all_valid, 1'b1);
        chk_val("d1_strobe_e6", load_strobe, 1'b0);
        tick();
        chk_val("d1_strobe_e7", load_strobe, 1'b1);
        tick();
        chk_val("d1_strobe_e8", load_strobe, 1'b0);
        strb = 0;
        run(10, strb);
        save_n = '1;
        run(10, strb);
        chk_val("d1_single_strobe", strb, 0);

        // Bounce: 3 low / 1 high never reaches 4 stable cycles
        data_input = 4'hC;
        strb = 0;
        for (int r = 0; r < 10; r++) begin
            save_n[0] = 1'b0;
            run(3, strb);
            save_n[0] = 1'b1;
            run(1, strb);
        end
        run(10, strb);
        chk_val("bounce_q", q, 8'hA5);
        chk_val("bounce_valid", valid, 2'b11);
        chk_val("bounce_strobe", strb, 0);
        press(0, 12, strb);
        chk_val("steady_q", q, 8'hAC);
        chk_val("steady_strobes", strb, 1);

        // Standalone clear: flags drop, data retained
        clear = 1'b1;
        tick();
        clear = 1'b0;
        chk_val("clr_valid", valid, 2'b00);
        chk_val("clr_all_valid", all_valid, 1'b0);
        chk_val("clr_q", q, 8'hAC);

        // Sequential mode: pointer walks 0 -> 1 -> 0 -> 1
        seq_mode = 1'b1;
        tick();
        chk_val("seq_ptr0", seq_ptr, 1'b0);
        data_input = 4'h3;
        press(CHANNELS, 12, strb);
        chk_val("seq1_q", q, 8'hA3);
        chk_val("seq1_valid", valid, 2'b01);
        chk_val("seq1_ptr", seq_ptr, 1'b1);
        chk_val("seq1_strobes", strb, 0);
        data_input = 4'h7;
        press(CHANNELS, 12, strb);
        chk_val("seq2_q", q, 8'h73);
        chk_val("seq2_valid", valid, 2'b11);
        chk_val("seq2_ptr", seq_ptr, 1'b0);
        chk_val("seq2_strobes", strb, 1);
        data_input = 4'h9;
        press(CHANNELS, 12, strb);
        chk_val("seq3_q", q, 8'h79);
        chk_val("seq3_ptr", seq_ptr, 1'b1);
        chk_val("seq3_strobes", strb, 1);
        data_input = 4'hF;
        press(0, 12, strb);
        chk_val("seq_direct_ignored_q", q, 8'h79);
        chk_val("seq_direct_ignored_ptr", seq_ptr, 1'b1);
        chk_val("seq_direct_ignored_strb", strb, 0);

        // Leaving sequential mode forces the pointer back to 0
        seq_mode = 1'b0;
        tick();
        chk_val("mode_ptr_reset", seq_ptr, 1'b0);
        chk_val("mode_valid_kept", valid, 2'b11);

        // Clear on the same edge as a press event wins
        data_input = 4'hF;
        save_n[0]  = 1'b0;
        for (int i = 0; i < 6; i++) tick();
        clear = 1'b1;
        tick();
        clear = 1'b0;
        chk_val("clrev_valid", valid, 2'b00);
        chk_val("clrev_ptr", seq_ptr, 1'b0);
        chk_val("clrev_q", q, 8'h79);
        strb = 0;
        run(5, strb);
        save_n = '1;
        run(10, strb);
        chk_val("clrev_no_strobe", strb, 0);
        chk_val("clrev_q_after", q, 8'h79);

        // Reset mid-press with the button held through and past reset
        data_input = 4'h6;
        save_n[1]  = 1'b0;
        for (int i = 0; i < 7; i++) tick();
        chk_val("midrst_load_q", q, 8'h69);
        chk_val("midrst_load_valid", valid, 2'b10);
        for (int i = 7; i < 50; i++) tick();
        reset_n = 1'b1;
        tick();
        tick();
        chk_val("midrst_q_zero", q, 8'h00);
        chk_val("midrst_valid_zero", valid, 2'b00);
        reset_n = 1'b0;
        for (int i = 0; i < 6; i++) tick();
        chk_val("postrst_before_edge6", q, 8'h00);
        tick();
        chk_val("postrst_q", q, 8'h60);
        chk_val("postrst_valid", valid, 2'b10);
        strb = 0;
        run(40, strb);
        chk_val("postrst_single_load", q, 8'h60);
        save_n = '1;
        run(10, strb);
        chk_val("postrst_no_strobe", strb, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
